// File: rtl/fsm_fetch_dispatch.sv
// Control-unit top sequencer: fetches an instruction, decodes its class, starts the
// matching sub-FSM and waits for its done, with a watchdog on both handshakes.
module fsm_fetch_dispatch #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    input  logic [5:0]  done,
    output logic        memory_start,
    output logic        sel_mem_operation,
    output logic [31:0] insn,
    output logic [31:0] code,
    output logic [5:0]  start,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic        timeout,
    output logic [63:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_DISPATCH,
        S_WAIT_DONE,
        S_HALT
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cls_dec;
    logic [5:0]  cls_q;
    logic [15:0] wdog;
    logic        wdog_expired;
    logic        strobe;

    // One-hot class in done/start bit order; all-zero means illegal.
    function automatic logic [5:0] classify(input logic [31:0] w);
        logic [5:0] c;
        c = 6'b000000;
        if (w[1:0] == 2'b11) begin
            case (w[6:2])
                5'd4, 5'd5, 5'd6, 5'd12, 5'd14: c = 6'b000001;
                5'd0, 5'd1, 5'd8, 5'd9:         c = 6'b000010;
                5'd24:                          c = 6'b000100;
                5'd25, 5'd27:                   c = 6'b001000;
                5'd13:                          c = 6'b010000;
                5'd20:                          c = 6'b100000;
                default:                        c = 6'b000000;
            endcase
        end
        return c;
    endfunction

    assign cls_dec      = classify(insn);
    assign wdog_expired = (wdog == WDOG_LAST);
    // Only the strobe belonging to the current wait state counts; foreign done bits are masked.
    assign strobe       = (state == S_FETCH_WAIT) ? mem_done : |(done & cls_q);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:       if (run) state_nxt = S_FETCH_REQ;
            S_FETCH_REQ:  state_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (strobe)            state_nxt = S_DECODE;
                else if (wdog_expired) state_nxt = S_HALT;
            end
            S_DECODE:     state_nxt = (cls_dec == 6'b000000) ? S_HALT : S_DISPATCH;
            S_DISPATCH:   state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (strobe)            state_nxt = run ? S_FETCH_REQ : S_IDLE;
                else if (wdog_expired) state_nxt = S_HALT;
            end
            S_HALT:       state_nxt = S_HALT;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            insn    <= '0;
            cls_q   <= '0;
            wdog    <= '0;
            instret <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples the pre-edge values.
            state <= state_nxt;
            case (state)
                S_FETCH_REQ, S_DISPATCH:   wdog <= '0;
                S_FETCH_WAIT, S_WAIT_DONE: wdog <= wdog + 16'd1;
                default:                   wdog <= wdog;
            endcase
            if (state == S_FETCH_WAIT && mem_done)
                insn <= mem_rdata;
            if (state == S_DECODE) begin
                cls_q <= cls_dec;
                if (cls_dec == 6'b000000)
                    illegal <= 1'b1;
            end
            if (state == S_WAIT_DONE && strobe)
                instret <= instret + 64'd1;
            if ((state == S_FETCH_WAIT || state == S_WAIT_DONE) && !strobe && wdog_expired)
                timeout <= 1'b1;
        end
    end

    assign memory_start      = (state == S_FETCH_REQ);
    assign sel_mem_operation = 1'b0;
    assign start             = (state == S_DISPATCH) ? cls_q : 6'b000000;
    assign busy              = !(state == S_IDLE || state == S_HALT);
    assign halted            = (state == S_HALT);
    assign code              = (insn[1:0] == 2'b11) ? (32'd1 << insn[6:2]) : 32'd0;

endmodule

// File: tb/tb_fsm_fetch_dispatch.sv
// Self-checking bench for fsm_fetch_dispatch: directed and randomized instruction streams
// checked cycle by cycle against a class-table / retire-count reference model.
module tb_fsm_fetch_dispatch;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [5:0]  done;
    logic        memory_start;
    logic        sel_mem_operation;
    logic [31:0] insn;
    logic [31:0] code;
    logic [5:0]  start;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        timeout;
    logic [63:0] instret;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_instret = '0;
    logic [31:0] last_word = '0;

    fsm_fetch_dispatch #(.TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .mem_done         (mem_done),
        .mem_rdata        (mem_rdata),
        .done             (done),
        .memory_start     (memory_start),
        .sel_mem_operation(sel_mem_operation),
        .insn             (insn),
        .code             (code),
        .start            (start),
        .busy             (busy),
        .halted           (halted),
        .illegal          (illegal),
        .timeout          (timeout),
        .instret          (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: observed no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference class table: 0 alu, 1 mem, 2 branch, 3 jump, 4 upper, 5 fp, -1 illegal.
    function automatic int exp_class(input logic [31:0] w);
        logic [4:0] op;
        op = w[6:2];
        if (w[1:0] != 2'b11) return -1;
        if (op inside {5'd4, 5'd5, 5'd6, 5'd12, 5'd14}) return 0;
        if (op inside {5'd0, 5'd1, 5'd8, 5'd9})         return 1;
        if (op == 5'd24)                                return 2;
        if (op inside {5'd25, 5'd27})                   return 3;
        if (op == 5'd13)                                return 4;
        if (op == 5'd20)                                return 5;
        return -1;
    endfunction

    function automatic logic [31:0] rand_legal();
        int          ops [14] = '{4, 5, 6, 12, 14, 0, 1, 8, 9, 24, 25, 27, 13, 20};
        logic [31:0] w;
        w      = $urandom;
        w[6:2] = 5'(ops[$urandom_range(0, 13)]);
        w[1:0] = 2'b11;
        return w;
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [31:0] w;
        w = $urandom;
        for (int t = 0; t < 200 && exp_class(w) >= 0; t++) w = $urandom;
        if (exp_class(w) >= 0) w = 32'hFFFF_FFFF;
        return w;
    endfunction

    task automatic check_halt(input string tag, input logic exp_illegal, input logic exp_timeout);
        check({tag, "_halted"},  64'(halted),  64'd1);
        check({tag, "_illegal"}, 64'(illegal), 64'(exp_illegal));
        check({tag, "_timeout"}, 64'(timeout), 64'(exp_timeout));
        check({tag, "_busy"},    64'(busy),    64'd0);
        check({tag, "_start"},   64'(start),   64'd0);
        check({tag, "_instret"}, instret,      exp_instret);
    endtask

    // Entered at the negedge of the FETCH_REQ cycle; leaves in WAIT_DONE cycle 1 (cls >= 0) or HALT.
    task automatic fetch_dispatch(input logic [31:0] word, input int mem_lat,
                                  input bit early_junk, output int cls);
        logic [31:0] exp_code;
        logic [5:0]  sel;
        cls      = exp_class(word);
        exp_code = '0;
        if (word[1:0] == 2'b11) exp_code[word[6:2]] = 1'b1;
        check("fetch_req", 64'(memory_start), 64'd1);
        check("fetch_read", 64'(sel_mem_operation), 64'd0);
        mem_done  = early_junk;
        mem_rdata = ~word;
        step();
        mem_done = 1'b0;
        if (mem_lat > TIMEOUT) begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                mem_rdata = $urandom;
                step();
            end
            check_halt("fetch_wdog", 1'b0, 1'b1);
            cls = -2;
            return;
        end
        for (int i = 1; i < mem_lat; i++) begin
            check("fetch_wait_req_low", 64'(memory_start), 64'd0);
            mem_rdata = $urandom;
            step();
        end
        mem_done  = 1'b1;
        mem_rdata = word;
        step();
        mem_done  = 1'b0;
        mem_rdata = $urandom;
        check("decode_insn", 64'(insn), 64'(word));
        check("decode_code", 64'(code), 64'(exp_code));
        check("decode_start", 64'(start), 64'd0);
        last_word = word;
        step();
        if (cls < 0) begin
            check_halt("illegal", 1'b1, 1'b0);
            return;
        end
        sel = 6'd1 << cls;
        check("dispatch_start", 64'(start), 64'(sel));
        check("dispatch_code_held", 64'(code), 64'(exp_code));
        step();
        check("wait_start_low", 64'(start), 64'd0);
        check("wait_insn_held", 64'(insn), 64'(word));
    endtask

    // Entered in WAIT_DONE cycle 1; done_lat > TIMEOUT means the strobe never comes.
    task automatic finish_insn(input int cls, input int done_lat, input bit drop_run);
        logic [5:0] sel;
        sel = 6'd1 << cls;
        if (drop_run) run = 1'b0;
        if (done_lat > TIMEOUT) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                if (k == TIMEOUT) check("wdog_not_early", 64'(halted), 64'd0);
                done = (6'($urandom) | 6'b000100) & ~sel;
                step();
            end
            done = '0;
            check_halt("done_wdog", 1'b0, 1'b1);
            return;
        end
        for (int k = 1; k < done_lat; k++) begin
            done = 6'($urandom) & ~sel;
            step();
        end
        done = sel | (6'($urandom) & ~sel);
        step();
        done        = '0;
        exp_instret = exp_instret + 64'd1;
        check("retire_instret", instret, exp_instret);
        if (run) begin
            check("next_fetch", 64'(memory_start), 64'd1);
        end else begin
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_no_fetch", 64'(memory_start), 64'd0);
            check("idle_halted", 64'(halted), 64'd0);
        end
    endtask

    task automatic run_insn(input logic [31:0] word, input int mem_lat, input int done_lat,
                            input bit drop_run, input bit early_junk);
        int cls;
        fetch_dispatch(word, mem_lat, early_junk, cls);
        if (cls >= 0) finish_insn(cls, done_lat, drop_run);
    endtask

    task automatic post_halt();
        for (int i = 0; i < 4; i++) begin
            run       = 1'b1;
            mem_done  = 1'b1;
            mem_rdata = $urandom;
            done      = 6'h3f;
            step();
            check("halt_stays", 64'(halted), 64'd1);
            check("halt_no_fetch", 64'(memory_start), 64'd0);
            check("halt_no_start", 64'(start), 64'd0);
            check("halt_instret", instret, exp_instret);
            check("halt_insn", 64'(insn), 64'(last_word));
        end
        mem_done = 1'b0;
        done     = '0;
    endtask

    task automatic do_reset(input bit keep_run);
        reset    = 1'b1;
        run      = keep_run;
        mem_done = 1'b0;
        done     = '0;
        step();
        step();
        reset       = 1'b0;
        exp_instret = '0;
        last_word   = '0;
        check("rst_memory_start", 64'(memory_start), 64'd0);
        check("rst_sel_mem_op", 64'(sel_mem_operation), 64'd0);
        check("rst_insn", 64'(insn), 64'd0);
        check("rst_code", 64'(code), 64'd0);
        check("rst_start", 64'(start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_instret", instret, 64'd0);
        step();
        check("rst_first_fetch", 64'(memory_start), 64'(keep_run));
    endtask

    initial begin
        int cls;
        reset     = 1'b1;
        run       = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        done      = '0;
        @(negedge clk);

        do_reset(1'b1);
        run_insn(32'h003100B3, 1, 1, 1'b0, 1'b0);
        run_insn(32'h00A08093, 1, 2, 1'b0, 1'b1);
        run_insn(32'h0000006F, 2, 1, 1'b0, 1'b0);
        run_insn(32'h00000037, 3, 3, 1'b0, 1'b1);
        for (int n = 0; n < 24; n++)
            run_insn(rand_legal(), $urandom_range(1, 5), $urandom_range(1, 6), 1'b0, 1'($urandom));

        fetch_dispatch(32'hFFFFFFFF, 1, 1'b0, cls);
        post_halt();

        // WAIT_DONE watchdog: expiry, then strobe on the last allowed cycle.
        do_reset(1'b1);
        fetch_dispatch(32'h003100B3, 1, 1'b0, cls);
        finish_insn(cls, TIMEOUT + 1, 1'b0);
        post_halt();
        do_reset(1'b1);
        fetch_dispatch(32'h003100B3, 1, 1'b0, cls);
        finish_insn(cls, TIMEOUT, 1'b0);
        check("edge_done_no_timeout", 64'(timeout), 64'd0);
        check("edge_done_not_halted", 64'(halted), 64'd0);

        run_insn(rand_legal(), TIMEOUT, 1, 1'b0, 1'b0);
        check("edge_mem_no_timeout", 64'(timeout), 64'd0);
        fetch_dispatch(rand_legal(), TIMEOUT + 1, 1'b0, cls);
        post_halt();

        // Dropping run mid-instruction lets it retire, then the block idles until run returns.
        do_reset(1'b1);
        run_insn(rand_legal(), 1, 2, 1'b0, 1'b0);
        run_insn(rand_legal(), 2, 4, 1'b1, 1'b0);
        check("drop_instret", instret, 64'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("drop_stays_idle", 64'(memory_start), 64'd0);
        end
        run = 1'b1;
        step();
        run_insn(rand_legal(), 1, 1, 1'b0, 1'b0);
        check("resume_instret", instret, 64'd3);

        // Reset while a sub-FSM is outstanding; its late done must not retire anything.
        fetch_dispatch(32'h003100B3, 1, 1'b0, cls);
        reset = 1'b1;
        run   = 1'b0;
        step();
        reset       = 1'b0;
        exp_instret = '0;
        last_word   = '0;
        mem_done    = 1'b1;
        done        = 6'h3f;
        step();
        step();
        check("late_done_instret", instret, 64'd0);
        check("late_done_busy", 64'(busy), 64'd0);
        check("late_done_start", 64'(start), 64'd0);
        check("late_done_fetch", 64'(memory_start), 64'd0);
        check("late_done_insn", 64'(insn), 64'd0);
        mem_done = 1'b0;
        done     = '0;
        run      = 1'b1;
        step();
        run_insn(32'h003100B3, 1, 1, 1'b0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            do_reset(1'b1);
            fetch_dispatch(rand_illegal(), $urandom_range(1, 3), 1'($urandom), cls);
            post_halt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
